// File: rtl/sram_if_mem_tester_pkg.sv
// Shared definitions for the SRAM-port memory tester.
//  - state_t      : tester FSM state encoding
//  - MODE_ADDR/MODE_LFSR : data pattern selection
//  - LFSR_TAPS    : feedback mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//  - DEFAULT_SEED : LFSR seed used at the start of every LFSR pass
//  - lfsr_next()  : one Fibonacci shift (shift left, feedback into bit 0)
package sram_if_mem_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_CHECK   = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_if_mem_tester_lfsr16.sv
// 16-bit Fibonacci LFSR used as the pseudo-random data source.
// Ports:
//  clk     : clock
//  i_rst   : synchronous active-high reset, loads SEED
//  i_load  : load i_seed (has priority over i_step)
//  i_step  : advance one shift
//  i_seed  : value loaded by i_load
//  o_value : current LFSR state
module sram_if_mem_tester_lfsr16
    import sram_if_mem_tester_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [15:0] i_seed,
    output logic [15:0] o_value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (i_load) begin
            value_d = i_seed;
        end else if (i_step) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;

endmodule

// File: rtl/sram_if_mem_tester.sv
// Self-checking traffic generator for the SRAM-like port of the DDR wrapper.
// For every address it writes a pattern, reads it back and compares; it sweeps
// 0..ADDR_LAST and then repeats with the next (inverted) pattern.
// Ports:
//  clk, i_rst           : clock, synchronous active-high reset
//  i_start / i_stop     : begin sweep (from IDLE/FAULT) / finish current pair then IDLE
//  i_mode               : 0 address pattern, 1 LFSR pattern (sampled per pass)
//  wrap_*               : SRAM-like request port and ready/read-data return
//  o_busy               : not IDLE/FAULT
//  o_ok / o_err         : one-cycle compare result pulses
//  o_timeout            : sticky handshake timeout
//  o_pass_cnt/o_err_cnt : completed sweeps (wrapping) / mismatches (saturating)
//  o_first_addr/_data   : address and read data of the first mismatch since start
module sram_if_mem_tester
    import sram_if_mem_tester_pkg::*;
#(
    parameter int                 ADDR_W      = 29,
    parameter logic [ADDR_W-1:0]  ADDR_LAST   = ADDR_W'('h0FFF_FFFF),
    parameter int                 TIMEOUT_CYC = 4096,
    parameter logic [15:0]        LFSR_SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_mode,
    output logic [31:0]       wrap_Addr,
    output logic              wrap_CS,
    output logic              wrap_L,
    output logic              wrap_U,
    output logic              wrap_WE,
    output logic [15:0]       wrap_WR,
    input  logic [15:0]       wrap_RD,
    input  logic              wrap_ready,
    output logic              o_busy,
    output logic              o_ok,
    output logic              o_err,
    output logic              o_timeout,
    output logic [15:0]       o_pass_cnt,
    output logic [15:0]       o_err_cnt,
    output logic [ADDR_W-1:0] o_first_addr,
    output logic [15:0]       o_first_data
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flip_q, flip_d;
    logic              mode_q, mode_d;
    logic              stop_q, stop_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              cs_q, cs_d;
    logic [15:0]       rd_q, rd_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       pass_cnt_q, pass_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              first_seen_q, first_seen_d;
    logic [ADDR_W-1:0] first_addr_q, first_addr_d;
    logic [15:0]       first_data_q, first_data_d;

    logic              lfsr_load;
    logic              lfsr_step;
    logic [15:0]       lfsr_value;
    logic [15:0]       pattern;
    logic [15:0]       expect_val;
    logic              stop_now;
    logic              in_wait;

    sram_if_mem_tester_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_load  (lfsr_load),
        .i_step  (lfsr_step),
        .i_seed  (LFSR_SEED),
        .o_value (lfsr_value)
    );

    // Expected data depends only on registers that change at CHECK, so it is
    // stable for the whole write/read pair.
    always_comb begin
        pattern    = (mode_q == MODE_ADDR) ? addr_q[15:0] : lfsr_value;
        expect_val = flip_q ? ~pattern : pattern;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        flip_d       = flip_q;
        mode_d       = mode_q;
        stop_d       = stop_q;
        to_cnt_d     = '0;
        cs_d         = cs_q;
        rd_d         = rd_q;
        ok_d         = 1'b0;
        err_d        = 1'b0;
        timeout_d    = timeout_q;
        pass_cnt_d   = pass_cnt_q;
        err_cnt_d    = err_cnt_q;
        first_seen_d = first_seen_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;
        stop_now     = stop_q | i_stop;
        in_wait      = 1'b0;

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (i_start) begin
                    state_d      = ST_WR_REQ;
                    addr_d       = '0;
                    flip_d       = 1'b0;
                    mode_d       = i_mode;
                    stop_d       = 1'b0;
                    timeout_d    = 1'b0;
                    pass_cnt_d   = '0;
                    err_cnt_d    = '0;
                    first_seen_d = 1'b0;
                    first_addr_d = '0;
                    first_data_d = '0;
                    lfsr_load    = 1'b1;
                end
            end

            // cs_q doubles as "ready was seen high": a request is only raised
            // once the wrapper is idle, and only counts as accepted when ready
            // falls while it is being held.
            ST_WR_REQ, ST_RD_REQ: begin
                in_wait = 1'b1;
                stop_d  = stop_now;
                if (wrap_ready) begin
                    cs_d = 1'b1;
                end else if (cs_q) begin
                    cs_d    = 1'b0;
                    state_d = (state_q == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
                end
            end

            ST_WR_WAIT: begin
                in_wait = 1'b1;
                stop_d  = stop_now;
                if (wrap_ready) begin
                    state_d = ST_RD_REQ;
                end
            end

            ST_RD_WAIT: begin
                in_wait = 1'b1;
                stop_d  = stop_now;
                if (wrap_ready) begin
                    rd_d    = wrap_RD;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                stop_d = stop_now;
                if (rd_q == expect_val) begin
                    ok_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (!first_seen_q) begin
                        first_seen_d = 1'b1;
                        first_addr_d = addr_q;
                        first_data_d = rd_q;
                    end
                end
                if (addr_q == ADDR_LAST) begin
                    addr_d     = '0;
                    pass_cnt_d = pass_cnt_q + 16'd1;
                    flip_d     = ~flip_q;
                    mode_d     = i_mode;
                    lfsr_load  = 1'b1;
                end else begin
                    addr_d    = addr_q + ADDR_W'(1);
                    lfsr_step = 1'b1;
                end
                state_d = stop_now ? ST_IDLE : ST_WR_REQ;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cycle counter for handshake waits; any state change restarts it.
        if (in_wait && (state_d == state_q)) begin
            if (to_cnt_q == TO_LAST) begin
                state_d   = ST_FAULT;
                timeout_d = 1'b1;
                cs_d      = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            flip_q       <= 1'b0;
            mode_q       <= 1'b0;
            stop_q       <= 1'b0;
            to_cnt_q     <= '0;
            cs_q         <= 1'b0;
            rd_q         <= '0;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            pass_cnt_q   <= '0;
            err_cnt_q    <= '0;
            first_seen_q <= 1'b0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            flip_q       <= flip_d;
            mode_q       <= mode_d;
            stop_q       <= stop_d;
            to_cnt_q     <= to_cnt_d;
            cs_q         <= cs_d;
            rd_q         <= rd_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            pass_cnt_q   <= pass_cnt_d;
            err_cnt_q    <= err_cnt_d;
            first_seen_q <= first_seen_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
        end
    end

    // All request signals are qualified by the registered chip select so they
    // drop together on the edge the request is accepted, faulted or reset.
    assign wrap_CS   = cs_q;
    assign wrap_L    = cs_q;
    assign wrap_U    = cs_q;
    assign wrap_WE   = cs_q && (state_q == ST_WR_REQ);
    assign wrap_Addr = cs_q ? {{(32-ADDR_W){1'b0}}, addr_q} : 32'h0;
    assign wrap_WR   = cs_q ? expect_val : 16'h0;

    assign o_busy       = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign o_ok         = ok_q;
    assign o_err        = err_q;
    assign o_timeout    = timeout_q;
    assign o_pass_cnt   = pass_cnt_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_first_addr = first_addr_q;
    assign o_first_data = first_data_q;

endmodule

// File: tb/tb_sram_if_mem_tester.sv
// Bench for sram_if_mem_tester: wrapper behavioural model on the SRAM port,
// expected request/result queues filled from the pattern rules, and monitors
// that pop and compare whenever the DUT issues a request or a result pulse.
module tb_sram_if_mem_tester;

    localparam int N_ADDR      = 4;
    localparam int TIMEOUT_CYC = 4096;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_mode = 1'b0;
    logic [31:0] wrap_Addr;
    logic        wrap_CS, wrap_L, wrap_U, wrap_WE;
    logic [15:0] wrap_WR;
    logic [15:0] wrap_RD = 16'h0;
    logic        wrap_ready = 1'b1;
    logic        o_busy, o_ok, o_err, o_timeout;
    logic [15:0] o_pass_cnt, o_err_cnt;
    logic [28:0] o_first_addr;
    logic [15:0] o_first_data;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [15:0] data;
    } req_t;

    req_t        exp_req[$];
    bit          exp_res[$];
    logic [15:0] fault_tbl[int];
    logic [15:0] mem_m[int];

    // wrapper model state
    int          mdl_mode = 0;   // 0 normal, 1 ready stuck high, 2 ready stuck low
    bit          busy_m = 0;
    int          cnt_m = 0;
    int          rd_idx = 0;
    int          stop_at = -1;
    bit          stop_pend = 0;
    logic [15:0] rd_val = 16'h0;
    req_t        cur_req;
    int          key_m;
    bit          res_exp;
    int          res_seen = 0;

    // expected end-of-run values
    int          exp_errs;
    int          exp_first_addr;
    logic [15:0] exp_first_data;
    int          exp_pass;

    sram_if_mem_tester #(
        .ADDR_W      (29),
        .ADDR_LAST   (29'd3),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_mode       (i_mode),
        .wrap_Addr    (wrap_Addr),
        .wrap_CS      (wrap_CS),
        .wrap_L       (wrap_L),
        .wrap_U       (wrap_U),
        .wrap_WE      (wrap_WE),
        .wrap_WR      (wrap_WR),
        .wrap_RD      (wrap_RD),
        .wrap_ready   (wrap_ready),
        .o_busy       (o_busy),
        .o_ok         (o_ok),
        .o_err        (o_err),
        .o_timeout    (o_timeout),
        .o_pass_cnt   (o_pass_cnt),
        .o_err_cnt    (o_err_cnt),
        .o_first_addr (o_first_addr),
        .o_first_data (o_first_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // LFSR value after k shifts from the seed, polynomial x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_at(input int k);
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < k; i++) begin
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        end
        return v;
    endfunction

    // Data for the t-th write/read pair since start: address index and pass
    // number follow from t; odd passes are inverted.
    function automatic logic [15:0] ref_pattern(input logic mode, input int t);
        int          a;
        int          p;
        logic [15:0] base;
        a    = t % N_ADDR;
        p    = t / N_ADDR;
        base = mode ? lfsr_at(a) : 16'(a);
        return (p % 2 == 1) ? ~base : base;
    endfunction

    task automatic plan_run(input logic mode, input int n);
        req_t        r;
        logic [15:0] d;
        int          a;
        exp_req.delete();
        exp_res.delete();
        exp_errs       = 0;
        exp_first_addr = 0;
        exp_first_data = 16'h0;
        exp_pass       = n / N_ADDR;
        for (int t = 0; t < n; t++) begin
            a = t % N_ADDR;
            d = ref_pattern(mode, t);
            r.we = 1'b1; r.addr = 32'(a); r.data = d;
            exp_req.push_back(r);
            r.we = 1'b0; r.data = 16'h0;
            exp_req.push_back(r);
            if (fault_tbl.exists(t) && fault_tbl[t] != 16'h0) begin
                if (exp_errs == 0) begin
                    exp_first_addr = a;
                    exp_first_data = d ^ fault_tbl[t];
                end
                exp_errs++;
                exp_res.push_back(1'b0);
            end else begin
                exp_res.push_back(1'b1);
            end
        end
    endtask

    // Wrapper model: ready drops 2 cycles after CS is seen, rises 5 later.
    always @(negedge clk) begin
        i_stop = 1'b0;
        if (i_rst) begin
            busy_m     = 0;
            cnt_m      = 0;
            stop_pend  = 0;
            wrap_ready = 1'b1;
        end else if (mdl_mode == 1) begin
            wrap_ready = 1'b1;
        end else if (mdl_mode == 2) begin
            wrap_ready = 1'b0;
        end else if (busy_m) begin
            cnt_m++;
            if (cnt_m == 2) wrap_ready = 1'b0;
            if (cnt_m == 4 && stop_pend) begin
                i_stop    = 1'b1;
                stop_pend = 0;
            end
            if (cnt_m == 7) begin
                wrap_ready = 1'b1;
                wrap_RD    = rd_val;
                busy_m     = 0;
            end
        end else begin
            wrap_ready = 1'b1;
            if (wrap_CS) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got we=%0b addr=0x%0h, expected no request", wrap_WE, wrap_Addr);
                end else begin
                    cur_req = exp_req.pop_front();
                    check("req_we", 32'(wrap_WE), 32'(cur_req.we));
                    check("req_addr", wrap_Addr, cur_req.addr);
                    check("req_lu", 32'({wrap_L, wrap_U}), 32'(2'b11));
                    if (cur_req.we) check("req_wdata", 32'(wrap_WR), 32'(cur_req.data));
                end
                key_m = int'(wrap_Addr);
                if (wrap_WE) begin
                    mem_m[key_m] = wrap_WR;
                end else begin
                    rd_val = mem_m.exists(key_m) ? mem_m[key_m] : 16'h0;
                    if (fault_tbl.exists(rd_idx)) rd_val = rd_val ^ fault_tbl[rd_idx];
                    if (rd_idx == stop_at) stop_pend = 1;
                    rd_idx++;
                end
                busy_m = 1;
                cnt_m  = 0;
            end
        end
    end

    // Result monitor: one line per compare the DUT reports.
    always @(negedge clk) begin
        if (!i_rst && (o_ok || o_err)) begin
            res_seen++;
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected: got ok=%0b err=%0b, expected no result", o_ok, o_err);
            end else begin
                res_exp = exp_res.pop_front();
                check("result_ok", 32'(o_ok), 32'(res_exp));
                check("result_err", 32'(o_err), 32'(!res_exp));
                $display("compare %0d: ok=%0b err=%0b err_cnt=%0d pass_cnt=%0d",
                         res_seen, o_ok, o_err, o_err_cnt, o_pass_cnt);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
    endtask

    // One sweep run of n write/read pairs, stopped during the last read.
    task automatic run(input logic mode, input int n);
        int cyc;
        plan_run(mode, n);
        rd_idx  = 0;
        stop_at = n - 1;
        i_mode  = mode;
        pulse_start();
        cyc = 0;
        while (o_busy && cyc < 40 * n + 100) begin
            @(negedge clk);
            cyc++;
        end
        if (o_busy) begin
            checks++;
            errors++;
            $display("FAIL run_done: got busy after %0d cycles, expected idle", cyc);
        end
        repeat (2) @(negedge clk);
        check("end_busy", 32'(o_busy), 32'd0);
        check("end_pass_cnt", 32'(o_pass_cnt), 32'(exp_pass));
        check("end_err_cnt", 32'(o_err_cnt), 32'(exp_errs));
        check("end_first_addr", 32'(o_first_addr), 32'(exp_first_addr));
        check("end_first_data", 32'(o_first_data), 32'(exp_first_data));
        check("end_timeout", 32'(o_timeout), 32'd0);
        check("end_cs", 32'(wrap_CS), 32'd0);
        check("end_req_left", 32'(exp_req.size()), 32'd0);
        check("end_res_left", 32'(exp_res.size()), 32'd0);
        $display("run mode=%0d pairs=%0d pass_cnt=%0d err_cnt=%0d", mode, n, o_pass_cnt, o_err_cnt);
    endtask

    // Ready stuck at one level: the tester must give up after TIMEOUT_CYC.
    task automatic run_timeout(input int stuck, input bit cs_expected);
        int cyc;
        bit cs_seen;
        exp_req.delete();
        exp_res.delete();
        mdl_mode = stuck;
        pulse_start();
        check("to_cleared_on_start", 32'(o_timeout), 32'd0);
        cyc     = 1;
        cs_seen = 0;
        while (!o_timeout && cyc < TIMEOUT_CYC + 200) begin
            if (wrap_CS) cs_seen = 1;
            @(negedge clk);
            cyc++;
        end
        check("to_flag", 32'(o_timeout), 32'd1);
        checks++;
        if (cyc < TIMEOUT_CYC - 4 || cyc > TIMEOUT_CYC + 4) begin
            errors++;
            $display("FAIL to_latency: got %0d cycles, expected about %0d", cyc, TIMEOUT_CYC);
        end
        check("to_cs", 32'(wrap_CS), 32'd0);
        check("to_we", 32'(wrap_WE), 32'd0);
        check("to_addr", wrap_Addr, 32'd0);
        check("to_busy", 32'(o_busy), 32'd0);
        check("to_cs_seen", 32'(cs_seen), 32'(cs_expected));
        $display("timeout stuck_mode=%0d cycles=%0d", stuck, cyc);
        mdl_mode = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int m;
        int n;

        // reset held 3 cycles
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(wrap_CS), 32'd0);
        check("rst_we", 32'(wrap_WE), 32'd0);
        check("rst_lu", 32'({wrap_L, wrap_U}), 32'd0);
        check("rst_addr", wrap_Addr, 32'd0);
        check("rst_wr", 32'(wrap_WR), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_okerr", 32'({o_ok, o_err}), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_pass_cnt", 32'(o_pass_cnt), 32'd0);
        check("rst_err_cnt", 32'(o_err_cnt), 32'd0);
        check("rst_first_addr", 32'(o_first_addr), 32'd0);
        check("rst_first_data", 32'(o_first_data), 32'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // address pattern, two full passes (second pass inverted)
        fault_tbl.delete();
        run(1'b0, 8);
        // single flipped bit at address 2 -> read 0x0003
        fault_tbl.delete();
        fault_tbl[2] = 16'h0001;
        run(1'b0, 4);
        // stop during the read of address 1
        fault_tbl.delete();
        run(1'b0, 2);
        // LFSR pattern, two passes
        run(1'b1, 8);

        // handshake timeouts, then recovery from FAULT
        run_timeout(1, 1'b1);
        run_timeout(2, 1'b0);
        fault_tbl.delete();
        run(1'b1, 5);

        // reset in the middle of a transaction
        plan_run(1'b0, 8);
        rd_idx  = 0;
        stop_at = -1;
        i_mode  = 1'b0;
        pulse_start();
        repeat (23) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", 32'(wrap_CS), 32'd0);
        check("midrst_wr", 32'(wrap_WR), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_pass_cnt", 32'(o_pass_cnt), 32'd0);
        i_rst = 1'b0;
        exp_req.delete();
        exp_res.delete();
        repeat (2) @(negedge clk);
        $display("mid-transaction reset done");

        // randomized runs with random single-bit read faults
        for (int r = 0; r < 8; r++) begin
            fault_tbl.delete();
            m = $urandom_range(0, 1);
            n = $urandom_range(1, 10);
            for (int t = 0; t < n; t++) begin
                if ($urandom_range(0, 3) == 0) fault_tbl[t] = 16'h1 << $urandom_range(0, 15);
            end
            run(m[0], n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
